// File: rtl/ddr3_para_rd_pkg.sv
// Shared constants for the DDR3 parameter reader: MIG command codes, address
// step per 128-bit read command, and the controller state encoding.
package ddr3_para_rd_pkg;

  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WR = 3'b000;

  localparam int unsigned ADDR_STEP = 8;

  localparam logic [2:0] LAST_WORD = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ddr3_para_rd_fifo.sv
// Synchronous first-word-fall-through beat buffer; dout shows the head entry
// whenever empty is low.
module para_rd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ddr3_para_rd.sv
// Reads rd_len 128-bit beats from MIG starting at rd_start_addr and streams
// them out as 16-bit words, low word first, with credit-based flow control.
module ddr3_para_rd
  import ddr3_para_rd_pkg::*;
#(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rd_data_valid,
  input  logic [127:0]      app_rd_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_start_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cmd_left_q, cmd_left_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic [2:0]        word_idx_q, word_idx_d;

  logic              in_job, accept, slot_free;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [127:0]      fifo_dout;

  para_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (128)
  ) u_fifo (
    .clk   (ui_clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (app_rd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // app_en depends only on registered state, so it cannot drop while app_rdy
  // is low: credit can only rise and cmd_left only falls on acceptance.
  always_comb begin
    in_job    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    app_en    = (state_q == ST_ISSUE) && (cmd_left_q != '0) && (credit_q != '0);
    app_cmd   = app_en ? CMD_RD : CMD_WR;
    app_addr  = addr_q;
    accept    = app_en && app_rdy;
    fifo_push = app_rd_data_valid && in_job && (beats_left_q != '0) && !fifo_full;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    err       = err_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

  // Words are read straight from the FIFO head; the beat is popped as its
  // last word is loaded, so a stalled consumer holds its credit.
  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_idx_d  = word_idx_q;
    fifo_pop    = 1'b0;
    if (slot_free) begin
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_dout[{word_idx_q, 4'b0000} +: 16];
        if (word_idx_q == LAST_WORD) begin
          fifo_pop   = 1'b1;
          word_idx_d = '0;
        end else begin
          word_idx_d = word_idx_q + 3'd1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_left_d   = cmd_left_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;
    credit_d     = credit_q - {{(CW-1){1'b0}}, accept} + {{(CW-1){1'b0}}, fifo_pop};
    case (state_q)
      ST_IDLE: begin
        if (app_rd_data_valid) err_d = 1'b1;
        if (rd_req && init_calib_complete) begin
          addr_d       = rd_start_addr;
          cmd_left_d   = rd_len;
          beats_left_d = rd_len;
          state_d      = (rd_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          addr_d     = addr_q + ADDR_W'(ADDR_STEP);
          cmd_left_d = cmd_left_q - LEN_W'(1);
          if (cmd_left_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((beats_left_q == '0) && fifo_empty && !out_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_push) beats_left_d = beats_left_q - LEN_W'(1);
  end

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cmd_left_q   <= '0;
      beats_left_q <= '0;
      credit_q     <= CW'(FIFO_DEPTH);
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_left_q   <= cmd_left_d;
      beats_left_q <= beats_left_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_idx_q   <= word_idx_d;
    end
  end

endmodule

// File: tb/tb_ddr3_para_rd.sv
// Self-checking bench for ddr3_para_rd: a MIG read model with fixed latency
// and a job-level reference for expected addresses and word order.
module tb_ddr3_para_rd;

  localparam int AW  = 28;
  localparam int LW  = 20;
  localparam int FD  = 16;
  localparam int LAT = 20;

  logic          ui_clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_calib_complete = 1'b1;
  logic          app_rdy = 1'b0;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rd_data_valid = 1'b0;
  logic [127:0]  app_rd_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_start_addr = '0;
  logic [LW-1:0] rd_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          busy, done, err;

  ddr3_para_rd #(
    .ADDR_W     (AW),
    .LEN_W      (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .ui_clk              (ui_clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .app_rdy             (app_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data),
    .rd_req              (rd_req),
    .rd_start_addr       (rd_start_addr),
    .rd_len              (rd_len),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  always #5 ui_clk = ~ui_clk;

  int errors = 0;
  int checks = 0;

  // Controls written only by the main sequence.
  int rdy_mode  = 0;  // 0 always ready, 1 one cycle in three, 2 random
  int ordy_mode = 0;  // 0 always ready, 1 never, 2 random
  int stray_req = 0;

  // Observations written only by the MIG/consumer process.
  logic [AW-1:0] obs_addr[$];
  logic [15:0]   obs_word[$];
  int            done_cnt = 0;
  int            stall_viol = 0;
  int            stray_done = 0;
  int            cyc = 0;

  // Expectations and per-job baselines written only by the main sequence.
  logic [AW-1:0] exp_addr[$];
  logic [15:0]   exp_word[$];
  int ab, wb, db, sb;

  function automatic logic [15:0] word_of(input logic [AW-1:0] a, input int i);
    return {a[15:3], 3'(i)};
  endfunction

  // MIG read model and output consumer, acting on falling edges.
  initial begin
    logic [AW-1:0] ret_addr[$];
    int            ret_due[$];
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] a;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (rst) begin
        ret_addr.delete();
        ret_due.delete();
        prev_stall        = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rdy           = 1'b0;
        out_ready         = 1'b0;
      end else begin
        if (prev_stall && (app_en !== 1'b1 || app_addr !== prev_addr)) stall_viol++;
        if (done === 1'b1) done_cnt++;
        case (rdy_mode)
          0:       app_rdy = 1'b1;
          1:       app_rdy = (cyc % 3 == 0);
          default: app_rdy = 1'($urandom_range(0, 1));
        endcase
        case (ordy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'b0;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        app_rd_data_valid = 1'b0;
        if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
          a = ret_addr.pop_front();
          void'(ret_due.pop_front());
          app_rd_data_valid = 1'b1;
          for (int i = 0; i < 8; i++) app_rd_data[16*i +: 16] = word_of(a, i);
        end else if (stray_req != stray_done) begin
          app_rd_data_valid = 1'b1;
          app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
          stray_done++;
        end
        if (app_en === 1'b1 && app_rdy) begin
          obs_addr.push_back(app_addr);
          ret_addr.push_back(app_addr);
          ret_due.push_back(cyc + LAT);
        end
        if (out_valid === 1'b1 && out_ready) obs_word.push_back(out_data);
        prev_stall = (app_en === 1'b1) && !app_rdy;
        prev_addr  = app_addr;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] addr, input int len, input bit model);
    @(negedge ui_clk);
    ab = obs_addr.size();
    wb = obs_word.size();
    db = done_cnt;
    sb = stall_viol;
    exp_addr.delete();
    exp_word.delete();
    if (model) begin
      for (int k = 0; k < len; k++) begin
        logic [AW-1:0] a;
        a = AW'(64'(addr) + 64'(8 * k));
        exp_addr.push_back(a);
        for (int i = 0; i < 8; i++) exp_word.push_back(word_of(a, i));
      end
    end
    rd_start_addr = addr;
    rd_len        = LW'(len);
    rd_req        = 1'b1;
    @(negedge ui_clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(done_cnt > db && busy === 1'b0) && n < budget) begin
      @(negedge ui_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, required idle", name, busy, n);
    end
    repeat (2) @(negedge ui_clk);
  endtask

  function automatic int addr_diff();
    for (int i = 0; i < exp_addr.size() && ab + i < obs_addr.size(); i++)
      if (obs_addr[ab + i] !== exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic int word_diff();
    for (int i = 0; i < exp_word.size() && wb + i < obs_word.size(); i++)
      if (obs_word[wb + i] !== exp_word[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    checks += 8;
    if (app_en !== 1'b0)    begin errors++; $display("FAIL reset app_en got %b want 0", app_en); end
    if (app_cmd !== 3'b000) begin errors++; $display("FAIL reset app_cmd got %b want 000", app_cmd); end
    if (app_addr !== '0)    begin errors++; $display("FAIL reset app_addr got %h want 0", app_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (out_data !== 16'h0) begin errors++; $display("FAIL reset out_data got %h want 0", out_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset done got %b want 0", done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset err got %b want 0", err); end
    @(negedge ui_clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    rdy_mode = 0; ordy_mode = 0;
    start_job(28'h100, 4, 1'b1);
    repeat (3) @(negedge ui_clk);
    rd_start_addr = 28'h5000; rd_len = 20'd7; rd_req = 1'b1;
    @(negedge ui_clk);
    rd_req = 1'b0;
    wait_idle("basic", 500);
    checks++;
    if (obs_addr.size() - ab != 4) begin errors++; $display("FAIL basic cmd_count got %0d want 4", obs_addr.size() - ab); end
    d = addr_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL basic addr[%0d] got %h want %h", d, obs_addr[ab + d], exp_addr[d]); end
    checks++;
    if (obs_word.size() - wb != 32) begin errors++; $display("FAIL basic word_count got %0d want 32", obs_word.size() - wb); end
    d = word_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL basic word[%0d] got %h want %h", d, obs_word[wb + d], exp_word[d]); end
    checks++;
    if (done_cnt - db != 1) begin errors++; $display("FAIL basic done_pulses got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_backpressure();
    int d;
    rdy_mode = 0; ordy_mode = 1;
    start_job(28'h2000, 40, 1'b1);
    repeat (200) @(negedge ui_clk);
    checks += 2;
    if (obs_addr.size() - ab != FD) begin errors++; $display("FAIL bp stalled_cmds got %0d want %0d", obs_addr.size() - ab, FD); end
    if (app_en !== 1'b0) begin errors++; $display("FAIL bp app_en_at_zero_credit got %b want 0", app_en); end
    ordy_mode = 0;
    wait_idle("bp", 2000);
    checks++;
    if (obs_word.size() - wb != 320) begin errors++; $display("FAIL bp word_count got %0d want 320", obs_word.size() - wb); end
    d = word_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL bp word[%0d] got %h want %h", d, obs_word[wb + d], exp_word[d]); end
    d = addr_diff();
    checks++;
    if (d >= 0 || obs_addr.size() - ab != 40) begin errors++; $display("FAIL bp addrs count %0d want 40 first_bad %0d", obs_addr.size() - ab, d); end
  endtask

  task automatic test_rdy_toggle();
    int d;
    rdy_mode = 1; ordy_mode = 2;
    start_job(AW'({$urandom} & 32'h0FFF_FFF8), 10, 1'b1);
    wait_idle("toggle", 2000);
    checks++;
    if (stall_viol - sb != 0) begin errors++; $display("FAIL toggle stall_changes got %0d want 0", stall_viol - sb); end
    d = addr_diff();
    checks++;
    if (d >= 0 || obs_addr.size() - ab != 10) begin errors++; $display("FAIL toggle addrs count %0d want 10 first_bad %0d", obs_addr.size() - ab, d); end
    d = word_diff();
    checks++;
    if (d >= 0 || obs_word.size() - wb != 80) begin errors++; $display("FAIL toggle words count %0d want 80 first_bad %0d", obs_word.size() - wb, d); end
  endtask

  task automatic test_wrap();
    int d;
    rdy_mode = 0; ordy_mode = 0;
    start_job(28'hFFFFFF8, 2, 1'b1);
    wait_idle("wrap", 500);
    checks++;
    if (obs_addr.size() - ab != 2) begin errors++; $display("FAIL wrap cmd_count got %0d want 2", obs_addr.size() - ab); end
    else begin
      checks++;
      if (obs_addr[ab + 1] !== 28'h0) begin errors++; $display("FAIL wrap second_addr got %h want 0000000", obs_addr[ab + 1]); end
    end
    d = word_diff();
    checks++;
    if (d >= 0 || obs_word.size() - wb != 16) begin errors++; $display("FAIL wrap words count %0d want 16 first_bad %0d", obs_word.size() - wb, d); end
  endtask

  task automatic test_calib_gate();
    init_calib_complete = 1'b0;
    start_job(28'h300, 3, 1'b0);
    repeat (5) @(negedge ui_clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL calib_gate busy got %b want 0", busy); end
    if (obs_addr.size() - ab != 0) begin errors++; $display("FAIL calib_gate cmds got %0d want 0", obs_addr.size() - ab); end
    init_calib_complete = 1'b1;
  endtask

  task automatic test_zero_len();
    start_job(28'h400, 0, 1'b1);
    repeat (2) @(negedge ui_clk);
    checks += 3;
    if (done_cnt - db != 1) begin errors++; $display("FAIL zero_len done_pulses got %0d want 1", done_cnt - db); end
    if (obs_addr.size() - ab != 0) begin errors++; $display("FAIL zero_len cmds got %0d want 0", obs_addr.size() - ab); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_len busy got %b want 0", busy); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL stray err_before got %b want 0", err); end
    stray_req++;
    repeat (4) @(negedge ui_clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL stray err_after got %b want 1", err); end
    repeat (3) @(negedge ui_clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL stray err_sticky got %b want 1", err); end
  endtask

  task automatic test_mid_reset();
    int n, d;
    rdy_mode = 0; ordy_mode = 2;
    start_job(28'h8000, 12, 1'b1);
    n = 0;
    while (obs_addr.size() - ab < 12 && n < 200) begin
      @(negedge ui_clk);
      n++;
    end
    repeat (2) @(negedge ui_clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset pre_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks += 7;
    if (app_en !== 1'b0)    begin errors++; $display("FAIL mid_reset app_en got %b want 0", app_en); end
    if (app_addr !== '0)    begin errors++; $display("FAIL mid_reset app_addr got %h want 0", app_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset out_valid got %b want 0", out_valid); end
    if (out_data !== 16'h0) begin errors++; $display("FAIL mid_reset out_data got %h want 0", out_data); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_reset busy got %b want 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mid_reset done got %b want 0", done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL mid_reset err got %b want 0", err); end
    repeat (3) @(negedge ui_clk);
    rst = 1'b0;
    start_job(28'hA000, 3, 1'b1);
    wait_idle("post_reset", 500);
    d = addr_diff();
    checks++;
    if (d >= 0 || obs_addr.size() - ab != 3) begin errors++; $display("FAIL post_reset addrs count %0d want 3 first_bad %0d", obs_addr.size() - ab, d); end
    d = word_diff();
    checks++;
    if (d >= 0 || obs_word.size() - wb != 24) begin errors++; $display("FAIL post_reset words count %0d want 24 first_bad %0d", obs_word.size() - wb, d); end
  endtask

  task automatic test_random();
    int d, len;
    for (int j = 0; j < 4; j++) begin
      rdy_mode  = 2;
      ordy_mode = (j == 0) ? 0 : 2;
      len = $urandom_range(1, 24);
      start_job(AW'({$urandom} & 32'h0FFF_FFF8), len, 1'b1);
      wait_idle("random", 3000);
      d = addr_diff();
      checks++;
      if (d >= 0 || obs_addr.size() - ab != len) begin errors++; $display("FAIL random%0d addrs count %0d want %0d first_bad %0d", j, obs_addr.size() - ab, len, d); end
      d = word_diff();
      checks++;
      if (d >= 0 || obs_word.size() - wb != 8 * len) begin errors++; $display("FAIL random%0d words count %0d want %0d first_bad %0d", j, obs_word.size() - wb, 8 * len, d); end
      checks++;
      if (done_cnt - db != 1 || stall_viol - sb != 0) begin errors++; $display("FAIL random%0d done_pulses %0d want 1 stall_changes %0d want 0", j, done_cnt - db, stall_viol - sb); end
    end
  endtask

  initial begin
    repeat (3) @(negedge ui_clk);
    test_reset();
    repeat (2) @(negedge ui_clk);
    test_basic();
    test_backpressure();
    test_rdy_toggle();
    test_wrap();
    test_calib_gate();
    test_zero_len();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
